// File: rtl/modulos_net_ctrl.sv
// modulos_net_ctrl
//   Bank of NUM_MOD registered on/off output channels. Channels are written by CPU store
//   instructions and by 12-bit network command words. Network words pass through a small FIFO
//   with a valid/ready handshake. A word whose packet id repeats the previous accepted id is
//   dropped at ingress. FIFO pops lose arbitration to CPU writes.
//
// Ports
//   clock_in          rising-edge clock for all logic
//   reset_in_n        synchronous reset, active low
//   instruction       CPU instruction word (store-to-module decode)
//   valor             CPU target channel index
//   reg2              CPU write data (==1 turns the channel on, anything else turns it off)
//   network_in        network command {cmd[11:9], pkt id[8:5], addr[4:0]}
//   network_valid_in  network_in holds a command
//   network_ready_out FIFO can accept a command (not full)
//   modu              channel states
//   indis/pkdis/mddis cmd / pkt id / addr of the last applied valid network command
//   fifo_level_out    current FIFO occupancy
//   err_cnt_out       saturating count of rejected commands (CPU and network)
//   dup_cnt_out       saturating count of duplicate network commands dropped at ingress
module modulos_net_ctrl #(
    parameter int unsigned NUM_MOD    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clock_in,
    input  logic                          reset_in_n,
    input  logic [31:0]                   instruction,
    input  logic [31:0]                   valor,
    input  logic [31:0]                   reg2,
    input  logic [11:0]                   network_in,
    input  logic                          network_valid_in,
    output logic                          network_ready_out,
    output logic [NUM_MOD-1:0]            modu,
    output logic [2:0]                    indis,
    output logic [3:0]                    pkdis,
    output logic [4:0]                    mddis,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic [CNT_W-1:0]              err_cnt_out,
    output logic [CNT_W-1:0]              dup_cnt_out
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] CMD_SET = 3'b001;
    localparam logic [2:0] CMD_CLR = 3'b010;
    localparam logic [2:0] CMD_TGL = 3'b011;
    localparam logic [2:0] CMD_ALL = 3'b100;

    // State
    logic [11:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     cnt_q, cnt_d;
    logic [3:0]         trk_id_q, trk_id_d;
    logic               trk_vld_q, trk_vld_d;
    logic [NUM_MOD-1:0] modu_q, modu_d;
    logic [2:0]         indis_q, indis_d;
    logic [3:0]         pkdis_q, pkdis_d;
    logic [4:0]         mddis_q, mddis_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   dup_q, dup_d;

    // Decode
    logic               cpu_wr, cpu_in_range;
    logic               accept, dup, push, pop;
    logic [11:0]        head;
    logic [2:0]         head_cmd;
    logic [3:0]         head_pkt;
    logic [4:0]         head_addr;
    logic               net_ok;
    logic               err_inc;
    logic [NUM_MOD-1:0] cpu_mask, net_mask;

    logic unused_instr;
    assign unused_instr = ^instruction[26:2];

    assign cpu_wr       = (instruction[31:27] == 5'b10001) && (instruction[1:0] == 2'b11);
    assign cpu_in_range = valor < NUM_MOD;

    // Ready comes from the registered count only, so a pop cannot make room in the same cycle.
    assign network_ready_out = (cnt_q != FULL_CNT);
    assign accept = network_valid_in && network_ready_out;
    assign dup    = accept && trk_vld_q && (network_in[8:5] == trk_id_q);
    assign push   = accept && !dup;
    // CPU writes take the apply slot; a pending network command waits a cycle.
    assign pop    = !cpu_wr && (cnt_q != '0);

    assign head      = mem_q[rd_ptr_q];
    assign head_cmd  = head[11:9];
    assign head_pkt  = head[8:5];
    assign head_addr = head[4:0];

    always_comb begin
        net_ok = 1'b0;
        unique case (head_cmd)
            CMD_SET, CMD_CLR, CMD_TGL: net_ok = {27'd0, head_addr} < NUM_MOD;
            CMD_ALL:                   net_ok = 1'b1;
            default:                   net_ok = 1'b0;
        endcase
    end

    always_comb begin
        cpu_mask = '0;
        net_mask = '0;
        for (int i = 0; i < NUM_MOD; i++) begin
            cpu_mask[i] = (valor == unsigned'(i));
            net_mask[i] = ({27'd0, head_addr} == unsigned'(i));
        end
    end

    assign err_inc = (cpu_wr && !cpu_in_range) || (pop && !net_ok);

    always_comb begin
        modu_d    = modu_q;
        indis_d   = indis_q;
        pkdis_d   = pkdis_q;
        mddis_d   = mddis_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        trk_id_d  = trk_id_q;
        trk_vld_d = trk_vld_q;
        err_d     = err_q;
        dup_d     = dup_q;

        if (cpu_wr && cpu_in_range) begin
            modu_d = (reg2 == 32'd1) ? (modu_q | cpu_mask) : (modu_q & ~cpu_mask);
        end else if (pop && net_ok) begin
            unique case (head_cmd)
                CMD_SET: modu_d = modu_q | net_mask;
                CMD_CLR: modu_d = modu_q & ~net_mask;
                CMD_TGL: modu_d = modu_q ^ net_mask;
                default: modu_d = '0;
            endcase
            indis_d = head_cmd;
            pkdis_d = head_pkt;
            mddis_d = head_addr;
        end

        if (push) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            trk_id_d  = network_in[8:5];
            trk_vld_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (err_inc && (err_q != {CNT_W{1'b1}})) err_d = err_q + 1'b1;
        if (dup && (dup_q != {CNT_W{1'b1}}))     dup_d = dup_q + 1'b1;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            trk_id_q  <= '0;
            trk_vld_q <= 1'b0;
            modu_q    <= '0;
            indis_q   <= '0;
            pkdis_q   <= '0;
            mddis_q   <= '0;
            err_q     <= '0;
            dup_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            trk_id_q  <= trk_id_d;
            trk_vld_q <= trk_vld_d;
            modu_q    <= modu_d;
            indis_q   <= indis_d;
            pkdis_q   <= pkdis_d;
            mddis_q   <= mddis_d;
            err_q     <= err_d;
            dup_q     <= dup_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clock_in) begin
        if (push) mem_q[wr_ptr_q] <= network_in;
    end

    assign modu           = modu_q;
    assign indis          = indis_q;
    assign pkdis          = pkdis_q;
    assign mddis          = mddis_q;
    assign fifo_level_out = cnt_q;
    assign err_cnt_out    = err_q;
    assign dup_cnt_out    = dup_q;

endmodule

// File: tb/tb_modulos_net_ctrl.sv
module tb_modulos_net_ctrl;

    localparam logic [31:0] CPU_WR = 32'h8800_0003;

    logic        clock_in = 1'b0;
    logic        reset_in_n;
    logic [31:0] instruction, valor, reg2;
    logic [11:0] network_in;
    logic        network_valid_in;
    logic        network_ready_out;
    logic [7:0]  modu;
    logic [2:0]  indis;
    logic [3:0]  pkdis;
    logic [4:0]  mddis;
    logic [2:0]  fifo_level_out;
    logic [7:0]  err_cnt_out, dup_cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    modulos_net_ctrl #(.NUM_MOD(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clock_in          (clock_in),
        .reset_in_n        (reset_in_n),
        .instruction       (instruction),
        .valor             (valor),
        .reg2              (reg2),
        .network_in        (network_in),
        .network_valid_in  (network_valid_in),
        .network_ready_out (network_ready_out),
        .modu              (modu),
        .indis             (indis),
        .pkdis             (pkdis),
        .mddis             (mddis),
        .fifo_level_out    (fifo_level_out),
        .err_cnt_out       (err_cnt_out),
        .dup_cnt_out       (dup_cnt_out)
    );

    always #5 clock_in = ~clock_in;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in_n = 1'b0; instruction = '0; valor = '0; reg2 = '0;
        network_in = '0; network_valid_in = 1'b0;
        tick(); tick();
        reset_in_n = 1'b1;
        n_cmp++; if (modu !== 8'h00) begin n_err++; $display("FAIL reset_modu: got %h want 00", modu); end
        n_cmp++; if (fifo_level_out !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level_out); end
        n_cmp++; if (network_ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", network_ready_out); end
        n_cmp++; if ({err_cnt_out, dup_cnt_out} !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", {err_cnt_out, dup_cnt_out}); end
        n_cmp++; if ({indis, pkdis, mddis} !== 12'h0) begin n_err++; $display("FAIL reset_disp: got %h want 000", {indis, pkdis, mddis}); end
    endtask

    task automatic test_cpu_write();
        instruction = CPU_WR; valor = 32'd3; reg2 = 32'd1;
        tick();
        instruction = '0;
        n_cmp++; if (modu !== 8'h08) begin n_err++; $display("FAIL cpu_on: got %h want 08", modu); end
        instruction = CPU_WR; reg2 = 32'd2;
        tick();
        instruction = '0;
        n_cmp++; if (modu !== 8'h00) begin n_err++; $display("FAIL cpu_off: got %h want 00", modu); end
    endtask

    task automatic test_net_set();
        network_in = 12'b001_0001_00101; network_valid_in = 1'b1;
        tick();
        network_valid_in = 1'b0;
        n_cmp++; if (modu !== 8'h00) begin n_err++; $display("FAIL net_lat1: got %h want 00", modu); end
        n_cmp++; if (fifo_level_out !== 3'd1) begin n_err++; $display("FAIL net_push_lvl: got %0d want 1", fifo_level_out); end
        tick();
        n_cmp++; if (modu !== 8'h20) begin n_err++; $display("FAIL net_set: got %h want 20", modu); end
        n_cmp++; if ({indis, pkdis, mddis} !== {3'd1, 4'd1, 5'd5}) begin n_err++; $display("FAIL net_disp: got %h want %h", {indis, pkdis, mddis}, {3'd1, 4'd1, 5'd5}); end
    endtask

    task automatic test_dup_and_toggle();
        network_in = 12'b001_0001_00101; network_valid_in = 1'b1;
        tick();
        network_valid_in = 1'b0;
        n_cmp++; if (dup_cnt_out !== 8'd1) begin n_err++; $display("FAIL dup_cnt: got %0d want 1", dup_cnt_out); end
        n_cmp++; if (fifo_level_out !== 3'd0) begin n_err++; $display("FAIL dup_nopush: got %0d want 0", fifo_level_out); end
        tick();
        n_cmp++; if (modu !== 8'h20) begin n_err++; $display("FAIL dup_modu: got %h want 20", modu); end
        network_in = 12'b011_0010_00101; network_valid_in = 1'b1;
        tick();
        network_valid_in = 1'b0;
        tick();
        n_cmp++; if (modu !== 8'h00) begin n_err++; $display("FAIL toggle: got %h want 00", modu); end
        n_cmp++; if ({indis, pkdis} !== {3'd3, 4'd2}) begin n_err++; $display("FAIL toggle_disp: got %h want %h", {indis, pkdis}, {3'd3, 4'd2}); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w [6];
        logic [2:0]  exp_lvl [6];
        for (int k = 0; k < 6; k++) w[k] = {3'b001, 4'(k + 3), 5'(k + 1)};
        exp_lvl = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        instruction = CPU_WR; valor = 32'd0; reg2 = 32'd1;
        network_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            network_in = w[k];
            tick();
        end
        network_in = w[4];
        n_cmp++; if (fifo_level_out !== 3'd4) begin n_err++; $display("FAIL b2b_full_lvl: got %0d want 4", fifo_level_out); end
        n_cmp++; if (network_ready_out !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0", network_ready_out); end
        tick(); tick();
        n_cmp++; if (fifo_level_out !== 3'd4) begin n_err++; $display("FAIL b2b_hold_lvl: got %0d want 4", fifo_level_out); end
        n_cmp++; if (modu !== 8'h01) begin n_err++; $display("FAIL b2b_cpu: got %h want 01", modu); end
        instruction = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 1) network_in = w[5];
            if (k == 2) network_valid_in = 1'b0;
            n_cmp++; if (mddis !== 5'(k + 1) || pkdis !== 4'(k + 3)) begin n_err++; $display("FAIL b2b_order%0d: got addr %0d pkt %0d want addr %0d pkt %0d", k, mddis, pkdis, k + 1, k + 3); end
            n_cmp++; if (fifo_level_out !== exp_lvl[k]) begin n_err++; $display("FAIL b2b_drain_lvl%0d: got %0d want %0d", k, fifo_level_out, exp_lvl[k]); end
        end
        n_cmp++; if (modu !== 8'h7F) begin n_err++; $display("FAIL b2b_final: got %h want 7f", modu); end
    endtask

    task automatic test_errors();
        network_valid_in = 1'b1;
        network_in = {3'b001, 4'd9, 5'd9};
        tick();
        network_in = {3'b111, 4'd10, 5'd0};
        tick();
        network_valid_in = 1'b0;
        tick();
        instruction = CPU_WR; valor = 32'd20; reg2 = 32'd1;
        tick();
        instruction = '0;
        n_cmp++; if (err_cnt_out !== 8'd3) begin n_err++; $display("FAIL err_cnt: got %0d want 3", err_cnt_out); end
        n_cmp++; if (modu !== 8'h7F) begin n_err++; $display("FAIL err_modu: got %h want 7f", modu); end
        n_cmp++; if ({indis, pkdis, mddis} !== {3'd1, 4'd8, 5'd6}) begin n_err++; $display("FAIL err_disp: got %h want %h", {indis, pkdis, mddis}, {3'd1, 4'd8, 5'd6}); end
    endtask

    task automatic test_reset_mid();
        instruction = CPU_WR; valor = 32'd0; reg2 = 32'd1;
        network_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            network_in = {3'b010, 4'(11 + k), 5'(k + 1)};
            tick();
        end
        network_valid_in = 1'b0;
        n_cmp++; if (fifo_level_out !== 3'd3) begin n_err++; $display("FAIL mid_lvl: got %0d want 3", fifo_level_out); end
        reset_in_n = 1'b0;
        tick();
        reset_in_n = 1'b1; instruction = '0;
        n_cmp++; if (fifo_level_out !== 3'd0) begin n_err++; $display("FAIL mid_rst_lvl: got %0d want 0", fifo_level_out); end
        n_cmp++; if (modu !== 8'h00) begin n_err++; $display("FAIL mid_rst_modu: got %h want 00", modu); end
        n_cmp++; if ({err_cnt_out, dup_cnt_out} !== 16'h0) begin n_err++; $display("FAIL mid_rst_cnt: got %h want 0000", {err_cnt_out, dup_cnt_out}); end
        tick(); tick();
        n_cmp++; if (modu !== 8'h00 || fifo_level_out !== 3'd0 || mddis !== 5'd0) begin n_err++; $display("FAIL mid_late: got modu %h lvl %0d addr %0d want 00 0 0", modu, fifo_level_out, mddis); end
    endtask

    task automatic test_dup_saturate();
        network_in = {3'b001, 4'd1, 5'd0}; network_valid_in = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        network_valid_in = 1'b0;
        tick();
        n_cmp++; if (dup_cnt_out !== 8'd255) begin n_err++; $display("FAIL dup_sat: got %0d want 255", dup_cnt_out); end
        n_cmp++; if (modu !== 8'h01) begin n_err++; $display("FAIL dup_sat_modu: got %h want 01", modu); end
    endtask

    initial begin
        #2;
        test_reset();
        test_cpu_write();
        test_net_set();
        test_dup_and_toggle();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_dup_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
